// File: rtl/rst_ctrl_pkg.sv
// Shared types for the reset controller: FSM state encoding
// and the helper that locates the clock-loss cause bit.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SEQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Clock-loss cause bit sits just above the request bits.
  function automatic int cause_clk_idx(input int num_src);
    return num_src;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// 1-bit synchroniser, STAGES flops deep, async reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_ctrl.sv
// Multi-source reset controller: merges requests and clock-OK,
// holds reset HOLD_CYC quiet cycles, then releases rst_out[0..]
// STAGE_CYC apart. Ports: clk, rst_n, clk_ok, rst_req, cause_clr,
// rst_out, busy, rst_cause. Cause logic under RST_CTRL_CAUSE_EN.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NUM_OUT     = 2,
  parameter int HOLD_CYC    = 24'hFFFFFF,
  parameter int STAGE_CYC   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_ok,
  input  logic [NUM_SRC-1:0] rst_req,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic [NUM_SRC:0]   rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int STG_W  = $clog2(STAGE_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYC);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGE_CYC - 1);

  if (HOLD_CYC == 0) begin : g_bad_hold
    $error("rst_ctrl: HOLD_CYC must be nonzero");
  end
  if (STAGE_CYC < 1) begin : g_bad_stage
    $error("rst_ctrl: STAGE_CYC must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_ctrl: SYNC_STAGES must be >= 2");
  end

  logic [NUM_SRC-1:0] req_s;
  logic               ok_s;
  logic               loss;
  logic               trig;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_req_sync
    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rst_req[i]),
      .q     (req_s[i])
    );
  end

  rst_sync #(.STAGES(SYNC_STAGES)) u_ok_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_ok),
    .q     (ok_s)
  );

  // Sync flops reset to 0, so clk_ok reads as lost until it
  // has propagated through the chain.
  assign loss = ~ok_s;
  assign trig = (|req_s) | loss;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STG_W-1:0]   stg_cnt;
  logic [NUM_OUT-1:0] out_nxt;

  // Releases walk a zero up from bit 0, keeping order monotonic.
  assign out_nxt = rst_out << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      stg_cnt  <= '0;
      rst_out  <= '1;
      busy     <= 1'b1;
    end else if (trig) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      stg_cnt  <= '0;
      rst_out  <= '1;
      busy     <= 1'b1;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_LAST) begin
            rst_out <= out_nxt;
            stg_cnt <= '0;
            if (out_nxt == '0) begin
              state <= ST_RUN;
              busy  <= 1'b0;
            end else begin
              state <= ST_SEQ;
            end
          end
        end
        ST_SEQ: begin
          if (stg_cnt == STG_LAST) begin
            stg_cnt <= '0;
            rst_out <= out_nxt;
            if (out_nxt == '0) begin
              state <= ST_RUN;
              busy  <= 1'b0;
            end
          end else begin
            stg_cnt <= stg_cnt + STG_W'(1);
          end
        end
        ST_RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state   <= ST_HOLD;
          rst_out <= '1;
          busy    <= 1'b1;
        end
      endcase
    end
  end

`ifdef RST_CTRL_CAUSE_EN
  localparam int CAUSE_CLK = cause_clk_idx(NUM_SRC);

  logic [NUM_SRC:0] cause_q;
  logic [NUM_SRC:0] cause_set;

  assign cause_set[NUM_SRC-1:0] = req_s;
  assign cause_set[CAUSE_CLK]   = loss;

  // Clear only in RUN; bits being set this cycle survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cause_q <= '0;
    else if (cause_clr && (state == ST_RUN))
      cause_q <= cause_set;
    else
      cause_q <= cause_q | cause_set;
  end

  assign rst_cause = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr;
  assign rst_cause = '0;
`endif

endmodule

// File: tb/tb_rst_ctrl.sv
// Self-checking bench for rst_ctrl: directed scenarios plus a
// random phase, checked against a quiet-edge-count model.
module tb_rst_ctrl;

  localparam int NS   = 4;
  localparam int NO   = 3;
  localparam int HC   = 8;
  localparam int SC   = 4;
  localparam int SS   = 2;
  localparam int FULL = HC + SC * (NO - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_ok = 1'b0;
  logic          cause_clr = 1'b0;
  logic [NS-1:0] rst_req = '0;
  logic [NO-1:0] rst_out;
  logic          busy;
  logic [NS:0]   rst_cause;

  int n_tests = 0;
  int n_fail  = 0;

  int            quiet;
  logic [NS-1:0] req_h [SS];
  logic          ok_h  [SS];
  logic [NS:0]   m_cause;

  always #5 clk = ~clk;

  rst_ctrl #(
    .NUM_SRC     (NS),
    .NUM_OUT     (NO),
    .HOLD_CYC    (HC),
    .STAGE_CYC   (SC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_ok    (clk_ok),
    .rst_req   (rst_req),
    .cause_clr (cause_clr),
    .rst_out   (rst_out),
    .busy      (busy),
    .rst_cause (rst_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k is released once the quiet run reaches HC + SC*k.
  function automatic logic [NO-1:0] m_out();
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++)
      r[k] = (quiet < HC + SC * k);
    return r;
  endfunction

  task automatic m_reset();
    quiet = 0;
    for (int i = 0; i < SS; i++) begin
      req_h[i] = '0;
      ok_h[i]  = 1'b0;
    end
    m_cause = '0;
  endtask

  task automatic m_edge();
    logic [NS-1:0] rs;
    logic          os;
    bit            trig;
    bit            in_run;
    rs     = req_h[SS-1];
    os     = ok_h[SS-1];
    trig   = (rs != '0) || !os;
    in_run = (quiet >= FULL);
`ifdef RST_CTRL_CAUSE_EN
    if (cause_clr && in_run) m_cause = {~os, rs};
    else                     m_cause = m_cause | {~os, rs};
`else
    if (in_run) m_cause = '0;
`endif
    if (trig) quiet = 0;
    else if (quiet < 100000) quiet++;
    for (int i = SS - 1; i > 0; i--) begin
      req_h[i] = req_h[i-1];
      ok_h[i]  = ok_h[i-1];
    end
    req_h[0] = rst_req;
    ok_h[0]  = clk_ok;
  endtask

  task automatic check_all();
    chk("rst_out", rst_out, m_out());
    chk("busy", busy, (quiet < FULL));
    chk("cause", rst_cause, m_cause);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    m_reset();

    // Power-on: held in reset.
    repeat (5) begin
      @(negedge clk);
      chk("por_out", rst_out, 3'b111);
      chk("por_busy", busy, 1'b1);
      chk("por_cause", rst_cause, '0);
    end
    clk_ok = 1'b1;
    rst_n  = 1'b1;
    e = 0;
    do begin tick(); e++; end while (rst_out[0] && e < 40);
    chk("por_rel0_edge", e, 10);
    repeat (SC) tick();
    chk("por_rel1", rst_out, 3'b100);
    repeat (SC) tick();
    chk("por_rel2", rst_out, 3'b000);
    chk("por_busy_low", busy, 1'b0);
    repeat (4) tick();

    // Clear causes in RUN, then a single-cycle request.
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    rst_req[2] = 1'b1;
    tick();
    rst_req = '0;
    e = 1;
    while (rst_out != 3'b111 && e < 20) begin tick(); e++; end
    chk("req_latency", e, 3);
    repeat (FULL + 6) tick();
    chk("req_run", rst_out, 3'b000);
`ifdef RST_CTRL_CAUSE_EN
    chk("req_cause", rst_cause, 5'b00100);
`endif

    // Re-trigger so the synced trig lands at hold count 6.
    rst_req[0] = 1'b1;
    tick();
    rst_req = '0;
    e = 0;
    while (quiet != 4 && e < 40) begin tick(); e++; end
    chk("retrig_wait", quiet, 4);
    rst_req[0] = 1'b1;
    tick();
    rst_req = '0;
    e = 1;
    while (rst_out[0] && e < 40) begin tick(); e++; end
    chk("retrig_edge", e, 11);

    // Clock loss during SEQ.
    chk("loss_pre", rst_out, 3'b110);
    clk_ok = 1'b0;
    tick();
    e = 1;
    while (rst_out != 3'b111 && e < 20) begin tick(); e++; end
    chk("loss_latency", e, 3);
    repeat (3) tick();
    clk_ok = 1'b1;
`ifdef RST_CTRL_CAUSE_EN
    chk("loss_cause", rst_cause[4], 1'b1);
`endif
    repeat (FULL + 6) tick();
    chk("loss_run", rst_out, 3'b000);

    // Clear in RUN colliding with a synced request.
    rst_req[1] = 1'b1;
    tick();
    rst_req = '0;
    tick();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
`ifdef RST_CTRL_CAUSE_EN
    chk("clr_set_prio", rst_cause, 5'b00010);
`endif
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
`ifdef RST_CTRL_CAUSE_EN
    chk("clr_in_hold", rst_cause, 5'b00010);
`endif
    repeat (FULL + 6) tick();

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      rst_req   = ($urandom_range(0, 19) == 0) ? NS'($urandom) : '0;
      clk_ok    = ($urandom_range(0, 39) != 0);
      cause_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_req   = '0;
    clk_ok    = 1'b1;
    cause_clr = 1'b0;
    repeat (FULL + 6) tick();

    // Async reset in the middle of SEQ.
    rst_req[3] = 1'b1;
    tick();
    rst_req = '0;
    e = 0;
    while (quiet != HC + 1 && e < 40) begin tick(); e++; end
    chk("async_pre", rst_out, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", rst_out, 3'b111);
    chk("async_busy", busy, 1'b1);
    chk("async_cause", rst_cause, '0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FULL + 8) tick();
    chk("async_run", rst_out, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_ctrl.md
Name: rst_ctrl

Overview:
- Parametrised multi-source, multi-domain reset controller; next generation of the single-counter power-on/clock-lock reset generator.
- Merges N reset request sources and a clock-OK indication, holds reset for a programmable time, then releases several reset domains in a fixed staggered order.
- Sits next to the clock block at the top level and drives the CPU, IO and peripheral reset domains.

Parameters:
- NUM_SRC, 4, number of reset request inputs (e.g. button, watchdog, software, debug)
- NUM_OUT, 2, number of sequenced reset outputs; bit 0 is released first
- HOLD_CYC, 24'hFFFFFF, trigger-free cycles required before the first release; HOLD_W = $clog2(HOLD_CYC+1)
- STAGE_CYC, 16, cycles between consecutive output releases (>=1)
- SYNC_STAGES, 2, synchroniser depth for rst_req and clk_ok (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low power-on reset
- clk_ok  in  1  clock/PLL locked, asynchronous
- rst_req  in  NUM_SRC  reset requests, active-high, asynchronous, any pulse width >= 1 clk
- cause_clr  in  1  synchronous pulse, clears the cause register
- rst_out  out  NUM_OUT  reset outputs, active-high
- busy  out  1  high unless in state RUN
- rst_cause  out  NUM_SRC+1  sticky cause bits; bit NUM_SRC = clock loss

Behaviour:
- rst_n low (async): rst_out all 1, busy 1, state HOLD, hold counter 0, stage counter 0, sync flops 0, rst_cause 0.
- trig = OR(synced rst_req) | ~synced clk_ok. Each synchroniser chain is SYNC_STAGES flops.
- States HOLD, SEQ, RUN.
  - Any state: trig at a clock edge -> state HOLD, hold counter 0, all rst_out 1 from that edge.
  - Latency: rst_req rise to rst_out all-1 = SYNC_STAGES+1 edges.
- HOLD:
  - Hold counter increments on each trig-free edge and saturates; it never wraps.
  - On the HOLD_CYC-th consecutive trig-free edge: rst_out[0] <= 0, stage counter 0, state SEQ; if NUM_OUT == 1, state RUN instead.
  - Any trig restarts the count from 0 (re-trigger extends the hold).
- SEQ:
  - Stage counter increments per edge.
  - Every STAGE_CYC edges the next rst_out bit clears, so rst_out[k] falls STAGE_CYC*k edges after rst_out[0].
  - Clearing rst_out[NUM_OUT-1] -> state RUN.
- RUN: rst_out all 0, busy 0. Stays in RUN until the next trig.
- Release order is monotonic: rst_out[k]=0 implies rst_out[j]=0 for all j<k.
- HOLD_CYC=0 is illegal; an elaboration-time check fails the build.

Optional Feature:
- Macro: RST_CTRL_CAUSE_EN.
- Defined:
  - rst_cause[i] sets on any edge where synced rst_req[i]=1.
  - rst_cause[NUM_SRC] sets where synced clk_ok=0.
  - Bits are sticky through the reset sequence.
  - cause_clr clears all bits, but only when state is RUN; set has priority over clear in the same cycle.
  - Cleared only by rst_n or cause_clr.
- Undefined: rst_cause tied to 0 and cause_clr ignored; no cause flops are synthesised.

Decomposition:
- Package rst_ctrl_pkg:
  - state encoding constants ST_HOLD=2'd0, ST_SEQ=2'd1, ST_RUN=2'd2
  - cause-bit index constant CAUSE_CLK = NUM_SRC
- Sub-module rst_sync:
  - SYNC_STAGES-deep, 1-bit, async-reset-to-0 synchroniser.
  - Instantiated NUM_SRC+1 times (clk_ok instance inverted after sync, so loss = 1).

Test Plan (HOLD_CYC=8, STAGE_CYC=4, NUM_OUT=3, NUM_SRC=4, SYNC_STAGES=2, cause enabled):
- Power-on: rst_n low 5 cycles, then high with clk_ok=1 -> rst_out=3'b111 and rst_cause=0 during reset; rst_out[0] falls at edge 8 after sync settles, [1] at +4, [2] at +8; busy falls with [2].
- Single-cycle rst_req[2] pulse in RUN -> rst_out=3'b111 exactly 3 edges later; full release sequence repeats; rst_cause=5'b00100.
- Re-trigger: rst_req[0] pulse at hold count 6 -> counter restarts; rst_out[0] falls 8 trig-free edges after the second pulse is synced.
- clk_ok drop while rst_out=3'b110 (SEQ) -> all outputs back to 1 after 3 edges; rst_cause[4]=1; sequence restarts after clk_ok returns.
- cause_clr in RUN with rst_req[1] asserted in the same synced cycle -> rst_cause[1] stays 1; cause_clr during HOLD -> no effect.
- rst_n asserted mid-SEQ -> rst_out=3'b111 and rst_cause=0 immediately, with no clock edge required.
